// File: rtl/alu_operand_loader.sv
// Operand loader in front of the arithmetic unit. Each press of the enter button captures
// the next value: A, then B, then the opcode. The loader then samples the arithmetic unit's
// result and flags into display registers.
module alu_operand_loader #(
    parameter int unsigned Nbit = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [Nbit-1:0] sw,
    input  logic [2:0]      op_sw,
    input  logic            enter,
    input  logic            clear,
    output logic [Nbit-1:0] A,
    output logic [Nbit-1:0] B,
    output logic [2:0]      operation,
    output logic            valid,
    input  logic [Nbit-1:0] result_in,
    input  logic [3:0]      flags_in,
    output logic [Nbit-1:0] result_q,
    output logic [3:0]      flags_q,
    output logic            done,
    output logic            err,
    output logic [2:0]      phase
);

    typedef enum logic [2:0] {
        StLoadA  = 3'd0,
        StLoadB  = 3'd1,
        StLoadOp = 3'd2,
        StExec   = 3'd3,
        StShow   = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic            s1_q, s2_q, s3_q;
    logic            enter_pulse;
    logic [Nbit-1:0] a_q, a_d;
    logic [Nbit-1:0] b_q, b_d;
    logic [2:0]      op_q, op_d;
    logic [Nbit-1:0] res_q, res_d;
    logic [3:0]      flg_q, flg_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            op_supported;

    // Button synchroniser plus edge flop; clear deliberately leaves these alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= enter;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign enter_pulse = s2_q & ~s3_q;

    // Opcodes 100, 110 and 111 have no arithmetic-unit implementation.
    assign op_supported = (op_sw == 3'b000) || (op_sw == 3'b001) || (op_sw == 3'b010) ||
                          (op_sw == 3'b011) || (op_sw == 3'b101);

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StLoadA;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            flg_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            flg_q   <= flg_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next-state and capture logic; clear overrides any pending enter pulse.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        flg_d   = flg_q;
        done_d  = 1'b0;
        err_d   = err_q;
        if (clear) begin
            state_d = StLoadA;
            a_d     = '0;
            b_d     = '0;
            op_d    = '0;
            res_d   = '0;
            flg_d   = '0;
            err_d   = 1'b0;
        end else begin
            unique case (state_q)
                StLoadA: begin
                    if (enter_pulse) begin
                        a_d     = sw;
                        state_d = StLoadB;
                    end
                end
                StLoadB: begin
                    if (enter_pulse) begin
                        b_d     = sw;
                        state_d = StLoadOp;
                    end
                end
                StLoadOp: begin
                    if (enter_pulse) begin
                        if (op_supported) begin
                            op_d    = op_sw;
                            err_d   = 1'b0;
                            state_d = StExec;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                StExec: begin
                    // The arithmetic unit is combinational, so its output is settled by now.
                    res_d   = result_in;
                    flg_d   = flags_in;
                    done_d  = 1'b1;
                    state_d = StShow;
                end
                StShow: begin
                    if (enter_pulse) begin
                        state_d = StLoadA;
                    end
                end
                default: state_d = StLoadA;
            endcase
        end
    end

    assign A         = a_q;
    assign B         = b_q;
    assign operation = op_q;
    assign valid     = (state_q == StExec) || (state_q == StShow);
    assign result_q  = res_q;
    assign flags_q   = flg_q;
    assign done      = done_q;
    assign err       = err_q;
    assign phase     = state_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Bench for alu_operand_loader: a small arithmetic-unit model feeds result_in/flags_in and a
// scoreboard queue holds the result each accepted operation should latch.
module tb_alu_operand_loader;

    localparam int unsigned Nbit = 8;

    logic            clk = 1'b0;
    logic            rst, clear, enter;
    logic [Nbit-1:0] sw;
    logic [2:0]      op_sw;
    logic [Nbit-1:0] A, B, result_in, result_q;
    logic [2:0]      operation, phase;
    logic [3:0]      flags_in, flags_q;
    logic            valid, done, err;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    logic [11:0] sb_q[$];

    alu_operand_loader #(.Nbit(Nbit)) dut (
        .clk       (clk),
        .rst       (rst),
        .sw        (sw),
        .op_sw     (op_sw),
        .enter     (enter),
        .clear     (clear),
        .A         (A),
        .B         (B),
        .operation (operation),
        .valid     (valid),
        .result_in (result_in),
        .flags_in  (flags_in),
        .result_q  (result_q),
        .flags_q   (flags_q),
        .done      (done),
        .err       (err),
        .phase     (phase)
    );

    always #5 clk = ~clk;

    // Returns {N,Z,C,V, result}.
    function automatic logic [11:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                              input logic [2:0] op);
        logic [8:0] wide;
        logic       c, v;
        wide = '0;
        c    = 1'b0;
        v    = 1'b0;
        case (op)
            3'b000: begin
                wide = {1'b0, a} + {1'b0, b};
                c    = wide[8];
                v    = (a[7] == b[7]) && (wide[7] != a[7]);
            end
            3'b001: begin
                wide = {1'b0, a} + {1'b0, ~b} + 9'd1;
                c    = wide[8];
                v    = (a[7] != b[7]) && (wide[7] != a[7]);
            end
            3'b010:  wide = {1'b0, a & b};
            3'b011:  wide = {1'b0, a | b};
            3'b101:  wide = {1'b0, a ^ b};
            default: wide = '0;
        endcase
        return {wide[7], (wide[7:0] == 8'd0), c, v, wide[7:0]};
    endfunction

    // Arithmetic-unit stand-in; outside EXEC it drives inverted values so a sample taken in the
    // wrong cycle is visible.
    logic [11:0] model_out;
    always_comb begin
        model_out = alu_model(A, B, operation);
        if (phase == 3'd3) begin
            result_in = model_out[7:0];
            flags_in  = model_out[11:8];
        end else begin
            result_in = ~model_out[7:0];
            flags_in  = ~model_out[11:8];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every done pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                logic [11:0] e;
                e = sb_q.pop_front();
                check("sb_result", {24'd0, result_q}, {24'd0, e[7:0]});
                check("sb_flags", {28'd0, flags_q}, {28'd0, e[11:8]});
            end
        end
    end

    // Press enter for 'hold' cycles; returns on the negedge after the capture edge.
    task automatic press(input logic [7:0] sw_v, input logic [2:0] op_v, input int hold);
        sw    = sw_v;
        op_sw = op_v;
        enter = 1'b1;
        repeat (hold) @(negedge clk);
        enter = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_A"}, {24'd0, A}, 32'd0);
        check({tag, "_B"}, {24'd0, B}, 32'd0);
        check({tag, "_op"}, {29'd0, operation}, 32'd0);
        check({tag, "_valid"}, {31'd0, valid}, 32'd0);
        check({tag, "_res"}, {24'd0, result_q}, 32'd0);
        check({tag, "_flags"}, {28'd0, flags_q}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_err"}, {31'd0, err}, 32'd0);
        check({tag, "_phase"}, {29'd0, phase}, 32'd0);
    endtask

    initial begin
        rst   = 1'b1;
        clear = 1'b0;
        enter = 1'b0;
        sw    = '0;
        op_sw = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("reset");

        // Basic add
        press(8'h25, 3'b000, 1);
        check("add_A", {24'd0, A}, 32'h25);
        check("add_phase1", {29'd0, phase}, 32'd1);
        press(8'h13, 3'b000, 1);
        check("add_B", {24'd0, B}, 32'h13);
        check("add_valid_loadop", {31'd0, valid}, 32'd0);
        sb_q.push_back(alu_model(8'h25, 8'h13, 3'b000));
        press(8'h00, 3'b000, 1);
        check("add_phase_exec", {29'd0, phase}, 32'd3);
        check("add_valid_exec", {31'd0, valid}, 32'd1);
        check("add_done_exec", {31'd0, done}, 32'd0);
        @(negedge clk);
        check("add_phase_show", {29'd0, phase}, 32'd4);
        check("add_done_pulse", {31'd0, done}, 32'd1);
        check("add_result", {24'd0, result_q}, 32'h38);
        check("add_flags", {28'd0, flags_q}, 32'h0);
        @(negedge clk);
        check("add_done_low", {31'd0, done}, 32'd0);
        check("add_done_count", done_cnt, 32'd1);
        press(8'h00, 3'b000, 1);
        check("show_exit_phase", {29'd0, phase}, 32'd0);
        check("show_exit_valid", {31'd0, valid}, 32'd0);
        check("show_keep_A", {24'd0, A}, 32'h25);
        check("show_keep_res", {24'd0, result_q}, 32'h38);

        // Held button
        press(8'h7F, 3'b000, 20);
        check("hold_A", {24'd0, A}, 32'h7F);
        check("hold_phase", {29'd0, phase}, 32'd1);
        sw = 8'hEE;
        repeat (5) @(negedge clk);
        check("hold_no_adv", {29'd0, phase}, 32'd1);
        check("hold_B_kept", {24'd0, B}, 32'h13);

        // Bad opcode, then recovery
        press(8'h0F, 3'b000, 1);
        check("bad_phase2", {29'd0, phase}, 32'd2);
        press(8'h00, 3'b110, 1);
        check("bad_err", {31'd0, err}, 32'd1);
        check("bad_phase", {29'd0, phase}, 32'd2);
        check("bad_op_kept", {29'd0, operation}, 32'd0);
        sb_q.push_back(alu_model(8'h7F, 8'h0F, 3'b001));
        press(8'h00, 3'b001, 1);
        check("fix_err", {31'd0, err}, 32'd0);
        check("fix_phase3", {29'd0, phase}, 32'd3);
        check("fix_op", {29'd0, operation}, 32'd1);
        @(negedge clk);
        check("fix_phase4", {29'd0, phase}, 32'd4);
        press(8'h00, 3'b000, 1);

        // Clear in LOAD_OP
        press(8'h11, 3'b000, 1);
        press(8'h22, 3'b000, 1);
        check("clr_pre_phase", {29'd0, phase}, 32'd2);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check_reset_outputs("clr");

        // Clear and enter pulse on the same edge in LOAD_B
        press(8'h33, 3'b000, 1);
        check("same_pre_phase", {29'd0, phase}, 32'd1);
        sw    = 8'h44;
        enter = 1'b1;
        @(negedge clk);
        enter = 1'b0;
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("same_phase", {29'd0, phase}, 32'd0);
        check("same_B", {24'd0, B}, 32'd0);
        repeat (3) @(negedge clk);
        check("same_phase_later", {29'd0, phase}, 32'd0);

        // rst during EXEC drops the sample
        press(8'h55, 3'b000, 1);
        press(8'h55, 3'b000, 1);
        press(8'h00, 3'b000, 1);
        check("rst_exec_phase", {29'd0, phase}, 32'd3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("rst_exec");
        repeat (4) @(negedge clk);
        check("final_done_count", done_cnt, 32'd2);
        check("sb_empty", sb_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_operand_loader.md
# alu_operand_loader

Sequential front-end that sits directly upstream of the arithmetic unit. It collects operand A, operand B and the 3-bit operation code from board switches, one per press of a single enter button. It presents the three values, held stable, to the arithmetic unit's A/B/operation inputs. It then samples the combinational result and N/Z/C/V flags back into display registers, so the board shows a frozen result until the next run.

## Interface
Parameters:
- Nbit, default 8, operand/result width; must match the arithmetic unit's Nbit.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- sw  in  Nbit  operand switches, sampled directly on capture.
- op_sw  in  3  operation switches, sampled directly on capture.
- enter  in  1  raw push button, active-high, asynchronous to clk.
- clear  in  1  synchronous active-high level, already synchronised by the caller.
- A  out  Nbit  captured operand A, to the arithmetic unit.
- B  out  Nbit  captured operand B, to the arithmetic unit.
- operation  out  3  captured opcode, to the arithmetic unit.
- valid  out  1  A/B/operation form a complete, stable request.
- result_in  in  Nbit  arithmetic unit result.
- flags_in  in  4  {N,Z,C,V} from the arithmetic unit.
- result_q  out  Nbit  latched result for display.
- flags_q  out  4  latched {N,Z,C,V}.
- done  out  1  one-cycle pulse when result_q/flags_q update.
- err  out  1  unsupported opcode was entered.
- phase  out  3  state code for LEDs.

## Operation
- Button path: enter passes through a 2-flop synchroniser (s1, s2), then a third flop s3. enter_pulse = s2 & ~s3, exactly one cycle per rising edge of the button. Holding enter high yields one pulse; enter must return low for ≥1 sampled cycle to re-arm.
- FSM states and phase codes:
  - LOAD_A=0
  - LOAD_B=1
  - LOAD_OP=2
  - EXEC=3
  - SHOW=4
- LOAD_A on enter_pulse: A<=sw, then go to LOAD_B.
- LOAD_B on enter_pulse: B<=sw, then go to LOAD_OP.
- LOAD_OP on enter_pulse:
  - Supported op_sw (000, 001, 010, 011, 101): operation<=op_sw, err<=0, go to EXEC.
  - Unsupported op_sw (100, 110, 111): operation is unchanged, err<=1, stay in LOAD_OP.
- EXEC lasts exactly one cycle, unconditionally:
  - result_q<=result_in and flags_q<=flags_in.
  - done<=1, go to SHOW.
- SHOW on enter_pulse: go to LOAD_A. A, B, operation, result_q and flags_q keep their values until overwritten.
- valid=1 only in EXEC and SHOW.
- enter_pulse has no effect in EXEC.
- clear, when high at an edge:
  - Sets state to LOAD_A.
  - Sets A, B, operation, result_q, flags_q, err and done to 0.
  - Does not touch the synchroniser flops.
- clear has priority over enter_pulse at the same edge.
- rst does everything clear does and also zeroes s1, s2 and s3. rst has priority over clear.
- Widths: all captures are straight copies; no arithmetic, extension or truncation.

## Timing
- Reset value of every output: A=0, B=0, operation=000, valid=0, result_q=0, flags_q=0000, done=0, err=0, phase=0.
- Enter latency: enter first sampled high at edge e0 → s2=1 after e1 → enter_pulse high for the cycle between e1 and e2 → capture/transition visible after e2.
- LOAD_OP to SHOW:
  - operation is captured at edge e2; EXEC is the cycle e2..e3.
  - The arithmetic unit is combinational, so result_in must settle within that cycle.
  - result_q/flags_q are sampled at e3; done is high for the cycle e3..e4 only.
- valid rises after e2 (entering EXEC) and falls the edge after the enter_pulse in SHOW.
- err stays high until a successful LOAD_OP capture, clear, or rst.
- rst or clear during EXEC: the sample is dropped, result_q=0, done stays 0.
- Mid-press clear: an enter already in the synchroniser produces its pulse after clear deasserts, if s2 rises then. The bench must account for this.

## Test plan
- Basic add:
  - Stimulus: press enter three times with sw=0x25, sw=0x13, op_sw=000; drive result_in=0x38, flags_in=0000 during EXEC.
  - Required: A=0x25, B=0x13, operation=000; valid rises with EXEC; done pulses once; result_q=0x38, phase=4.
- Held button: hold enter high for 20 cycles in LOAD_A with sw=0x7F → A=0x7F, phase=1 only; no further advance until a release and a new press.
- Bad opcode:
  - In LOAD_OP, press with op_sw=110 → err=1, phase=2, operation unchanged.
  - Then press with op_sw=001 → err=0, phase=3 then 4.
- Clear in LOAD_OP with A=0x11, B=0x22 → next cycle A=B=0, phase=0, valid=0, result_q=0.
- Clear and enter_pulse on the same edge in LOAD_B → phase=0, B unchanged at 0.
- rst asserted during EXEC with result_in=0xAA → result_q=0, done never pulses, all outputs at reset values.
